// File: rtl/udma_i2c_cmd_seq.sv
// Purpose: decode uDMA I2C command words into single bus ops; run WAIT/WAIT_EV/CFG/EOT/RPT locally.
// Latency: a bus op is presented one cycle after its command (WR: one cycle after its TX byte).
// Backpressure: commands are taken only in IDLE; TX bytes only in GETB; an op holds until op_ready_i.
module udma_i2c_cmd_seq #(
    parameter int NB_EVT = 4,
    parameter int RPT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       cmd_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [7:0]        data_tx_i,
    input  logic              data_tx_valid_i,
    output logic              data_tx_ready_o,
    input  logic [NB_EVT-1:0] ext_events_i,
    output logic [2:0]        op_o,
    output logic [7:0]        op_data_o,
    output logic              op_valid_o,
    input  logic              op_ready_i,
    output logic [15:0]       clkdiv_o,
    output logic              busy_o,
    output logic              eot_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GETB   = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_WAITEV = 3'd4
    } state_t;

    localparam logic [3:0] OPC_START   = 4'h0;
    localparam logic [3:0] OPC_WAIT_EV = 4'h1;
    localparam logic [3:0] OPC_STOP    = 4'h2;
    localparam logic [3:0] OPC_RD_ACK  = 4'h4;
    localparam logic [3:0] OPC_RD_NACK = 4'h6;
    localparam logic [3:0] OPC_WR      = 4'h8;
    localparam logic [3:0] OPC_EOT     = 4'h9;
    localparam logic [3:0] OPC_WAIT    = 4'hA;
    localparam logic [3:0] OPC_RPT     = 4'hC;
    localparam logic [3:0] OPC_CFG     = 4'hE;

    localparam logic [2:0] OP_START   = 3'd0;
    localparam logic [2:0] OP_STOP    = 3'd1;
    localparam logic [2:0] OP_RD_ACK  = 3'd2;
    localparam logic [2:0] OP_RD_NACK = 3'd3;
    localparam logic [2:0] OP_WR      = 3'd4;

    state_t           state, state_nxt;
    logic [2:0]       op_q;
    logic [7:0]       op_data_q;
    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_armed;
    logic [7:0]       wait_cnt;
    logic [1:0]       ev_idx;
    logic [15:0]      clkdiv_q;
    logic             eot_q;
    logic             err_q;

    logic [3:0] opc;
    logic       cmd_take;
    logic       is_local;
    logic       rpt_more;
    logic       ev_hit;
    logic       unused_cmd_bits;

    assign opc             = cmd_i[31:28];
    assign cmd_take        = cmd_valid_i && (state == S_IDLE);
    assign is_local        = (opc == OPC_WAIT) || (opc == OPC_WAIT_EV) ||
                             (opc == OPC_CFG)  || (opc == OPC_EOT);
    assign rpt_more        = rpt_armed && (rpt_cnt > {{(RPT_W-1){1'b0}}, 1'b1});
    assign ev_hit          = ext_events_i[ev_idx];
    assign unused_cmd_bits = &{1'b0, cmd_i[27:16]};

    assign op_o      = op_q;
    assign op_data_o = op_data_q;
    assign clkdiv_o  = clkdiv_q;
    assign eot_o     = eot_q;
    assign err_o     = err_q;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived handshake outputs.
    always_comb begin
        state_nxt       = state;
        cmd_ready_o     = 1'b0;
        data_tx_ready_o = 1'b0;
        op_valid_o      = 1'b0;
        busy_o          = 1'b1;
        case (state)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (cmd_valid_i) begin
                    case (opc)
                        OPC_START, OPC_STOP,
                        OPC_RD_ACK, OPC_RD_NACK: state_nxt = S_ISSUE;
                        OPC_WR:                  state_nxt = S_GETB;
                        OPC_WAIT:                state_nxt = S_WAIT;
                        OPC_WAIT_EV:             state_nxt = S_WAITEV;
                        default:                 state_nxt = S_IDLE;
                    endcase
                end
            end
            S_GETB: begin
                data_tx_ready_o = 1'b1;
                if (data_tx_valid_i) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                op_valid_o = 1'b1;
                if (op_ready_i) begin
                    if (rpt_more) state_nxt = (op_q == OP_WR) ? S_GETB : S_ISSUE;
                    else          state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (wait_cnt == 8'd0) state_nxt = S_IDLE;
            end
            S_WAITEV: begin
                if (ev_hit) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latched op, repeat bookkeeping, wait counter, config and status pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q      <= OP_START;
            op_data_q <= 8'd0;
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
            wait_cnt  <= 8'd0;
            ev_idx    <= 2'd0;
            clkdiv_q  <= 16'd0;
            eot_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            eot_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_take) begin
                        // A pending repeat cannot apply to a local command: flag it and drop it.
                        if (is_local && rpt_armed) begin
                            err_q     <= 1'b1;
                            rpt_armed <= 1'b0;
                            rpt_cnt   <= '0;
                        end
                        case (opc)
                            OPC_START:   begin op_q <= OP_START;   op_data_q <= 8'd0; end
                            OPC_STOP:    begin op_q <= OP_STOP;    op_data_q <= 8'd0; end
                            OPC_RD_ACK:  begin op_q <= OP_RD_ACK;  op_data_q <= 8'd0; end
                            OPC_RD_NACK: begin op_q <= OP_RD_NACK; op_data_q <= 8'd0; end
                            OPC_WR:      ;
                            OPC_WAIT:    wait_cnt <= cmd_i[7:0];
                            OPC_WAIT_EV: ev_idx   <= cmd_i[1:0];
                            OPC_CFG:     clkdiv_q <= cmd_i[15:0];
                            OPC_EOT:     eot_q    <= 1'b1;
                            OPC_RPT: begin
                                rpt_armed <= 1'b1;
                                rpt_cnt   <= (cmd_i[RPT_W-1:0] == '0) ?
                                             {{(RPT_W-1){1'b0}}, 1'b1} : cmd_i[RPT_W-1:0];
                            end
                            default:     err_q <= 1'b1;
                        endcase
                    end
                end
                S_GETB: begin
                    if (data_tx_valid_i) begin
                        op_q      <= OP_WR;
                        op_data_q <= data_tx_i;
                    end
                end
                S_ISSUE: begin
                    if (op_ready_i) begin
                        if (rpt_more) begin
                            rpt_cnt <= rpt_cnt - 1'b1;
                        end else begin
                            rpt_armed <= 1'b0;
                            rpt_cnt   <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt != 8'd0) wait_cnt <= wait_cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_udma_i2c_cmd_seq.sv
// Purpose: directed self-checking bench for the I2C command sequencer.
// Latency: checks one-cycle op/eot/err/clkdiv latency and WAIT/WAIT_EV durations.
// Backpressure: exercises op_ready_i toggling and gapped TX bytes.
module tb_udma_i2c_cmd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cmd;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  data_tx;
    logic        data_tx_valid;
    logic        data_tx_ready;
    logic [3:0]  ext_events;
    logic [2:0]  op;
    logic [7:0]  op_data;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] clkdiv;
    logic        busy;
    logic        eot;
    logic        err;

    int total = 0;
    int bad   = 0;
    logic [10:0] q[$];

    udma_i2c_cmd_seq #(.NB_EVT(4), .RPT_W(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_i(cmd), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .data_tx_i(data_tx), .data_tx_valid_i(data_tx_valid), .data_tx_ready_o(data_tx_ready),
        .ext_events_i(ext_events),
        .op_o(op), .op_data_o(op_data), .op_valid_o(op_valid), .op_ready_i(op_ready),
        .clkdiv_o(clkdiv), .busy_o(busy), .eot_o(eot), .err_o(err)
    );

    always #5 clk = ~clk;

    // Record every op handshake that will complete on the coming rising edge.
    always @(negedge clk) begin
        #1;
        if (!rst && op_valid && op_ready) q.push_back({op, op_data});
    end

    task automatic send_cmd(input logic [31:0] c);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL send_cmd timeout: cmd_ready=%0b required 1", cmd_ready);
        end
        cmd = c; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!data_tx_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL send_byte timeout: data_tx_ready=%0b required 1", data_tx_ready);
        end
        data_tx = b; data_tx_valid = 1'b1;
        @(negedge clk);
        data_tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL wait_idle timeout: busy=%0b required 0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd = '0; cmd_valid = 1'b0; data_tx = '0; data_tx_valid = 1'b0;
        ext_events = '0; op_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (op_valid !== 1'b0)  begin bad++; $display("FAIL reset_op_valid: got %0b want 0", op_valid); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        total++; if (clkdiv !== 16'h0)   begin bad++; $display("FAIL reset_clkdiv: got %h want 0000", clkdiv); end
        total++; if (op !== 3'd0 || op_data !== 8'h00) begin bad++; $display("FAIL reset_op: got %0d/%h want 0/00", op, op_data); end
        total++; if (eot !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_pulses: eot=%0b err=%0b want 0/0", eot, err); end
        total++; if (cmd_ready !== 1'b1 || data_tx_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: cmd=%0b tx=%0b want 1/0", cmd_ready, data_tx_ready); end
    endtask

    task automatic test_cfg();
        send_cmd(32'hE000_0064);
        total++; if (clkdiv !== 16'h0064) begin bad++; $display("FAIL cfg_clkdiv: got %h want 0064", clkdiv); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL cfg_busy: got %0b want 0", busy); end
    endtask

    task automatic test_sequence();
        op_ready = 1'b1; q.delete();
        send_cmd(32'h0000_0000);
        total++; if (op_valid !== 1'b1) begin bad++; $display("FAIL seq_start_latency: op_valid=%0b want 1", op_valid); end
        send_cmd(32'h8000_0000);
        send_byte(8'hA5);
        send_cmd(32'h2000_0000);
        send_cmd(32'h9000_0000);
        total++; if (eot !== 1'b1) begin bad++; $display("FAIL seq_eot_pulse: got %0b want 1", eot); end
        @(negedge clk);
        total++; if (eot !== 1'b0) begin bad++; $display("FAIL seq_eot_single: got %0b want 0", eot); end
        total++;
        if (q.size() != 3) begin
            bad++; $display("FAIL seq_op_count: got %0d want 3", q.size());
        end else if (q[0] !== {3'd0, 8'h00} || q[1] !== {3'd4, 8'hA5} || q[2] !== {3'd1, 8'h00}) begin
            bad++; $display("FAIL seq_op_order: got %h %h %h want 000 4a5 100", q[0], q[1], q[2]);
        end
    endtask

    task automatic test_rpt_rd();
        int n = 0;
        op_ready = 1'b0; q.delete();
        send_cmd(32'hC000_0003);
        send_cmd(32'h4000_0000);
        while ((busy || n == 0) && n < 40) begin
            op_ready = ~op_ready;
            @(negedge clk);
            n++;
        end
        op_ready = 1'b0;
        total++;
        if (q.size() != 3) begin
            bad++; $display("FAIL rpt_rd_count: got %0d want 3", q.size());
        end else if (q[0] !== {3'd2, 8'h00} || q[1] !== {3'd2, 8'h00} || q[2] !== {3'd2, 8'h00}) begin
            bad++; $display("FAIL rpt_rd_ops: got %h %h %h want 200 x3", q[0], q[1], q[2]);
        end
        op_ready = 1'b1; q.delete();
        send_cmd(32'h6000_0000);
        wait_idle();
        total++;
        if (q.size() != 1 || q[0] !== {3'd3, 8'h00}) begin
            bad++; $display("FAIL rpt_rd_cleared: got %0d ops want 1 RD_NACK", q.size());
        end
    endtask

    task automatic test_rpt_wr();
        op_ready = 1'b1; q.delete();
        send_cmd(32'hC000_0002);
        send_cmd(32'h8000_0000);
        repeat (3) @(negedge clk);
        total++; if (q.size() != 0 || data_tx_ready !== 1'b1) begin bad++; $display("FAIL rpt_wr_nobyte: ops=%0d tx_ready=%0b want 0/1", q.size(), data_tx_ready); end
        send_byte(8'h11);
        repeat (3) @(negedge clk);
        total++;
        if (q.size() != 1 || q[0] !== {3'd4, 8'h11} || data_tx_ready !== 1'b1) begin
            bad++; $display("FAIL rpt_wr_first: ops=%0d tx_ready=%0b want 1 op 4/11 and 1", q.size(), data_tx_ready);
        end
        send_byte(8'h22);
        wait_idle();
        total++;
        if (q.size() != 2 || q[1] !== {3'd4, 8'h22}) begin
            bad++; $display("FAIL rpt_wr_second: ops=%0d want 2 with 4/22 last", q.size());
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        op_ready = 1'b1; q.delete();
        send_cmd(32'hC000_0003);
        send_cmd(32'h0000_0000);
        while (op_valid && n < 20) begin @(negedge clk); n++; end
        total++; if (n != 3)       begin bad++; $display("FAIL b2b_valid_cycles: got %0d want 3", n); end
        total++; if (q.size() != 3) begin bad++; $display("FAIL b2b_op_count: got %0d want 3", q.size()); end
    endtask

    task automatic test_wait();
        int n = 0;
        send_cmd(32'hA000_0005);
        while (busy && n < 50) begin @(negedge clk); n++; end
        total++; if (n != 6) begin bad++; $display("FAIL wait_busy_cycles: got %0d want 6", n); end
        send_cmd(32'hA000_0000);
        n = 0;
        while (busy && n < 50) begin @(negedge clk); n++; end
        total++; if (n != 1) begin bad++; $display("FAIL wait0_busy_cycles: got %0d want 1", n); end
    endtask

    task automatic test_wait_ev();
        send_cmd(32'h1000_0002);
        ext_events = 4'b0010;
        @(negedge clk);
        ext_events = 4'b0000;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL waitev_wrong_idx: busy=%0b want 1", busy); end
        ext_events = 4'b0100;
        @(negedge clk);
        ext_events = 4'b0000;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL waitev_exit: busy=%0b want 0", busy); end
    endtask

    task automatic test_err();
        q.delete(); op_ready = 1'b1;
        send_cmd(32'h3000_0000);
        total++; if (err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL err_illegal: err=%0b busy=%0b want 1/0", err, busy); end
        @(negedge clk);
        total++; if (err !== 1'b0 || q.size() != 0) begin bad++; $display("FAIL err_single: err=%0b ops=%0d want 0/0", err, q.size()); end
        send_cmd(32'hC000_0005);
        send_cmd(32'hE000_1234);
        total++; if (err !== 1'b1 || clkdiv !== 16'h1234) begin bad++; $display("FAIL err_rpt_cfg: err=%0b clkdiv=%h want 1/1234", err, clkdiv); end
        send_cmd(32'h0000_0000);
        wait_idle();
        total++; if (q.size() != 1) begin bad++; $display("FAIL err_rpt_cleared: ops=%0d want 1", q.size()); end
    endtask

    task automatic test_reset_issue();
        op_ready = 1'b0;
        send_cmd(32'h2000_0000);
        total++; if (op_valid !== 1'b1 || op !== 3'd1) begin bad++; $display("FAIL rst_issue_pre: valid=%0b op=%0d want 1/1", op_valid, op); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (op_valid !== 1'b0 || busy !== 1'b0 || op !== 3'd0) begin bad++; $display("FAIL rst_issue_post: valid=%0b busy=%0b op=%0d want 0/0/0", op_valid, busy, op); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1 || clkdiv !== 16'h0) begin bad++; $display("FAIL rst_issue_idle: cmd_ready=%0b clkdiv=%h want 1/0000", cmd_ready, clkdiv); end
    endtask

    initial begin
        test_reset();
        test_cfg();
        test_sequence();
        test_rpt_rd();
        test_rpt_wr();
        test_back_to_back();
        test_wait();
        test_wait_ev();
        test_err();
        test_reset_issue();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
